// File: rtl/dac_cmd_pkg.sv
// Shared command/response encodings for the PS<->DAC command link.
// Imported by both the DAC-side responder and the PS-side command issuer.
package dac_cmd_pkg;

  localparam int unsigned CMD_RUN_PWL   = 0;
  localparam int unsigned CMD_RUN_TRIG  = 1;
  localparam int unsigned CMD_RUN_SHIFT = 2;
  localparam int unsigned CMD_HALT      = 3;
  localparam int unsigned CMD_RST       = 4;

  localparam int unsigned RESP_PWL_RDY  = 0;

  typedef enum logic [2:0] {
    ModeIdle   = 3'd0,
    ModeHalted = 3'd1,
    ModeShift  = 3'd2,
    ModeTrig   = 3'd3,
    ModePwl    = 3'd4
  } gen_mode_t;

endpackage

// File: rtl/dac_cmd_responder_resp_sender.sv
// Source side of the response handshake: latches a pending flag on any change and
// sends the value current at send time, so changes during a transfer coalesce.
module resp_sender #(
  parameter int unsigned RESP_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [RESP_WIDTH-1:0] i_data,
  input  logic                  i_change,
  input  logic                  i_xfer_rdy,
  input  logic                  i_xfer_done,
  output logic [RESP_WIDTH-1:0] o_resp,
  output logic                  o_resp_valid
);

  typedef enum logic {RIdle, RWait} resp_state_t;

  resp_state_t           r_state, w_state_d;
  logic                  r_pend, w_pend_d;
  logic [RESP_WIDTH-1:0] r_resp, w_resp_d;
  logic                  w_send;

  always_comb begin
    w_state_d = r_state;
    w_resp_d  = r_resp;
    // valid is qualified by rdy in the same cycle, so it can never lead rdy
    w_send    = (r_state == RIdle) && r_pend && i_xfer_rdy;
    unique case (r_state)
      RIdle: begin
        if (w_send) begin
          w_state_d = RWait;
          w_resp_d  = i_data;
        end
      end
      RWait: begin
        if (i_xfer_done) w_state_d = RIdle;
      end
      default: w_state_d = RIdle;
    endcase
    w_pend_d = (r_pend && !w_send) || i_change;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RIdle;
      r_pend  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= w_pend_d;
      r_resp  <= w_resp_d;
    end
  end

  assign o_resp       = w_send ? i_data : r_resp;
  assign o_resp_valid = w_send;

endmodule

// File: rtl/dac_cmd_responder.sv
// DAC-domain command endpoint: decodes command words into generator mode, seed and
// scale, tracks PWL table readiness and reports readiness changes back to the PS.
module dac_cmd_responder
  import dac_cmd_pkg::*;
#(
  parameter int unsigned CMD_WIDTH     = 5,
  parameter int unsigned RESP_WIDTH    = 2,
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned BATCH_SAMPLES = 16,
  parameter int unsigned BATCH_WIDTH   = SAMPLE_WIDTH * BATCH_SAMPLES,
  parameter int unsigned SCALE_WIDTH   = $clog2(SAMPLE_WIDTH)
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [BATCH_WIDTH+SCALE_WIDTH+CMD_WIDTH-1:0] i_ps_cmd,
  input  logic                                     i_valid_cmd,
  input  logic                                     i_pwl_load_start,
  input  logic                                     i_pwl_load_done,
  output gen_mode_t                                o_mode,
  output logic                                     o_mode_start,
  output logic                                     o_gen_rst,
  output logic [BATCH_WIDTH-1:0]                   o_seed,
  output logic [SCALE_WIDTH-1:0]                   o_scale_factor,
  output logic                                     o_pwl_rdy,
  output logic                                     o_cmd_err,
  output logic [RESP_WIDTH-1:0]                    o_resp,
  output logic                                     o_resp_valid,
  input  logic                                     i_resp_xfer_rdy,
  input  logic                                     i_resp_xfer_done
);

  gen_mode_t              r_mode, w_mode_d;
  logic [BATCH_WIDTH-1:0] r_seed, w_seed_d;
  logic [SCALE_WIDTH-1:0] r_scale, w_scale_d;
  logic                   r_pwl_rdy, w_pwl_rdy_d;
  logic                   r_mode_start, w_mode_start_d;
  logic                   r_gen_rst, w_gen_rst_d;
  logic                   r_cmd_err, w_cmd_err_d;

  logic [CMD_WIDTH-1:0]   w_cmd;
  logic [BATCH_WIDTH-1:0] w_seed_f;
  logic [SCALE_WIDTH-1:0] w_scale_f;
  logic [RESP_WIDTH-1:0]  w_resp_data;
  logic                   w_pwl_change;

  assign w_cmd     = i_ps_cmd[CMD_WIDTH-1:0];
  assign w_seed_f  = i_ps_cmd[CMD_WIDTH +: BATCH_WIDTH];
  assign w_scale_f = i_ps_cmd[CMD_WIDTH+BATCH_WIDTH +: SCALE_WIDTH];

  always_comb begin
    w_mode_d       = r_mode;
    w_seed_d       = r_seed;
    w_scale_d      = r_scale;
    w_pwl_rdy_d    = r_pwl_rdy;
    w_mode_start_d = 1'b0;
    w_gen_rst_d    = 1'b0;
    w_cmd_err_d    = 1'b0;

    if (i_pwl_load_done)  w_pwl_rdy_d = 1'b1;
    if (i_pwl_load_start) w_pwl_rdy_d = 1'b0;

    if (i_valid_cmd) begin
      w_scale_d = w_scale_f;
      if (w_cmd[CMD_RST]) begin
        w_mode_d    = ModeIdle;
        w_gen_rst_d = 1'b1;
        w_pwl_rdy_d = 1'b0;
        w_seed_d    = '0;
      end else if (w_cmd[CMD_HALT]) begin
        w_mode_d = ModeHalted;
      end else if (w_cmd[CMD_RUN_PWL]) begin
        if (r_pwl_rdy) begin
          w_mode_d       = ModePwl;
          w_mode_start_d = 1'b1;
        end else begin
          w_cmd_err_d = 1'b1;
        end
      end else if (w_cmd[CMD_RUN_SHIFT]) begin
        w_seed_d       = w_seed_f;
        w_mode_d       = ModeShift;
        w_mode_start_d = 1'b1;
      end else if (w_cmd[CMD_RUN_TRIG]) begin
        w_mode_d       = ModeTrig;
        w_mode_start_d = 1'b1;
      end
    end

    // A table rewrite must never be played, even if PWL was just requested.
    if (i_pwl_load_start && (w_mode_d == ModePwl)) begin
      w_mode_d       = ModeHalted;
      w_mode_start_d = 1'b0;
    end

    w_pwl_change              = (w_pwl_rdy_d != r_pwl_rdy);
    w_resp_data               = '0;
    w_resp_data[RESP_PWL_RDY] = r_pwl_rdy;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode       <= ModeIdle;
      r_seed       <= '0;
      r_scale      <= '0;
      r_pwl_rdy    <= 1'b0;
      r_mode_start <= 1'b0;
      r_gen_rst    <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_mode       <= w_mode_d;
      r_seed       <= w_seed_d;
      r_scale      <= w_scale_d;
      r_pwl_rdy    <= w_pwl_rdy_d;
      r_mode_start <= w_mode_start_d;
      r_gen_rst    <= w_gen_rst_d;
      r_cmd_err    <= w_cmd_err_d;
    end
  end

  resp_sender #(
    .RESP_WIDTH (RESP_WIDTH)
  ) u_resp_sender (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (w_resp_data),
    .i_change     (w_pwl_change),
    .i_xfer_rdy   (i_resp_xfer_rdy),
    .i_xfer_done  (i_resp_xfer_done),
    .o_resp       (o_resp),
    .o_resp_valid (o_resp_valid)
  );

  assign o_mode         = r_mode;
  assign o_seed         = r_seed;
  assign o_scale_factor = r_scale;
  assign o_pwl_rdy      = r_pwl_rdy;
  assign o_mode_start   = r_mode_start;
  assign o_gen_rst      = r_gen_rst;
  assign o_cmd_err      = r_cmd_err;

endmodule
